// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially from imem, buffers DEPTH entries for decode, flushes on redirect.
// Optional FETCH_QUEUE_STATS_EN adds saturating redirect and queue-full counters.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_src,
   input  logic [31:0] add_res,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        d_ready,
   output logic        d_valid,
   output logic [31:0] d_inst,
   output logic [31:0] d_pc,
   output logic [15:0] flush_cnt,
   output logic [15:0] full_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      fetch_pc;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [31:0]      inst_mem [DEPTH];
   logic [31:0]      pc_mem   [DEPTH];
   logic             full;
   logic             push;
   logic             pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign push      = !full && !pc_src;
   assign d_valid   = (count != '0) && !pc_src;
   assign pop       = d_valid && d_ready;
   assign imem_addr = fetch_pc;
   assign d_inst    = d_valid ? inst_mem[head] : 32'd0;
   assign d_pc      = d_valid ? pc_mem[head]   : 32'd0;

   // Control state: pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= 32'd0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (pc_src) begin
         fetch_pc <= add_res & 32'hFFFF_FFFC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            tail     <= tail + 1'b1;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (pop) head <= head + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage carries no reset; count alone decides what is live
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[tail] <= imem_rdata;
         pc_mem[tail]   <= fetch_pc + 32'd4;
      end
   end

`ifdef FETCH_QUEUE_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt <= 16'd0;
         full_cnt  <= 16'd0;
      end else begin
         if (pc_src) flush_cnt <= sat_inc(flush_cnt);
         if (full && !d_ready) full_cnt <= sat_inc(full_cnt);
      end
   end
`else
   assign flush_cnt = 16'd0;
   assign full_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based scoreboard of fetched entries plus directed scenario checks.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_src;
   logic [31:0] add_res;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        d_ready;
   logic        d_valid;
   logic [31:0] d_inst;
   logic [31:0] d_pc;
   logic [15:0] flush_cnt;
   logic [15:0] full_cnt;

   int          n_cmp = 0;
   int          n_err = 0;
   bit          armed = 1'b0;
   logic [63:0] sb [$];
   logic [31:0] m_pc;
   logic [15:0] m_flush;
   logic [15:0] m_full;

   always #5 clk = ~clk;

   assign imem_rdata = 32'hA000_0000 | imem_addr;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_src     (pc_src),
      .add_res    (add_res),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .d_ready    (d_ready),
      .d_valid    (d_valid),
      .d_inst     (d_inst),
      .d_pc       (d_pc),
      .flush_cnt  (flush_cnt),
      .full_cnt   (full_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [15:0] stat_exp(input logic [15:0] v);
`ifdef FETCH_QUEUE_STATS_EN
      return v;
`else
      return 16'd0 & v;
`endif
   endfunction

   // Check the current cycle against the model, then advance the model across the coming edge
   task automatic cycle();
      logic        exp_v;
      logic        do_push;
      logic [63:0] e;
      #1;
      exp_v = (sb.size() != 0) && !pc_src;
      if (armed) begin
         chk("imem_addr", imem_addr, m_pc);
         chk("d_valid", 32'(d_valid), 32'(exp_v));
         if (exp_v) begin
            e = sb[0];
            chk("d_inst", d_inst, e[63:32]);
            chk("d_pc", d_pc, e[31:0]);
         end else begin
            chk("d_inst_idle", d_inst, 32'd0);
            chk("d_pc_idle", d_pc, 32'd0);
         end
         chk("flush_cnt", 32'(flush_cnt), 32'(stat_exp(m_flush)));
         chk("full_cnt", 32'(full_cnt), 32'(stat_exp(m_full)));
      end
      if (rst) begin
         m_pc    = 32'd0;
         m_flush = 16'd0;
         m_full  = 16'd0;
         sb.delete();
         armed   = 1'b1;
      end else begin
         if (sb.size() == DEPTH && !d_ready) m_full = sat16(m_full);
         if (pc_src) begin
            sb.delete();
            m_pc    = {add_res[31:2], 2'b00};
            m_flush = sat16(m_flush);
         end else begin
            do_push = (sb.size() < DEPTH);
            if (exp_v && d_ready) void'(sb.pop_front());
            if (do_push) begin
               sb.push_back({32'hA000_0000 | m_pc, m_pc + 32'd4});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; pc_src = 1'b0; add_res = 32'd0; d_ready = 1'b0;
      cycle();

      // reset and redirect on the same edge: reset wins
      rst = 1'b1; pc_src = 1'b1; add_res = 32'h80;
      cycle();
      rst = 1'b0; pc_src = 1'b0;
      #1;
      chk("rst_over_redirect_addr", imem_addr, 32'd0);
      chk("rst_over_redirect_valid", 32'(d_valid), 32'd0);

      // three entries queued, then redirect to 0x40
      d_ready = 1'b0;
      repeat (3) cycle();
      pc_src = 1'b1; add_res = 32'h40;
      #1;
      chk("flush_cycle_valid", 32'(d_valid), 32'd0);
      cycle();
      pc_src = 1'b0;
      #1;
      chk("redirect_addr", imem_addr, 32'h40);
      chk("redirect_empty", 32'(d_valid), 32'd0);
      cycle();
      chk("target_inst", d_inst, 32'hA000_0040);
      chk("target_pc", d_pc, 32'h44);

      // unaligned target is forced to word alignment
      pc_src = 1'b1; add_res = 32'h43;
      cycle();
      pc_src = 1'b0;
      #1;
      chk("aligned_target", imem_addr, 32'h40);

      // third redirect, then stall until five full cycles accrue
      pc_src = 1'b1; add_res = 32'h100;
      cycle();
      pc_src = 1'b0;
      repeat (9) cycle();
      chk("stats_flush", 32'(flush_cnt), 32'(stat_exp(16'd3)));
      chk("stats_full", 32'(full_cnt), 32'(stat_exp(16'd5)));
      d_ready = 1'b1;
      repeat (6) cycle();

      // streaming after reset
      rst = 1'b1;
      cycle();
      rst = 1'b0; d_ready = 1'b1;
      cycle();
      chk("stream_inst0", d_inst, 32'hA000_0000);
      chk("stream_pc0", d_pc, 32'h4);
      cycle();
      chk("stream_pc1", d_pc, 32'h8);
      cycle();
      chk("stream_pc2", d_pc, 32'hC);

      // fill to capacity with decode stalled, then drain in order
      rst = 1'b1;
      cycle();
      rst = 1'b0; d_ready = 1'b0;
      repeat (6) cycle();
      chk("full_addr_hold", imem_addr, 32'h10);
      chk("full_head_hold", d_inst, 32'hA000_0000);
      d_ready = 1'b1;
      repeat (6) cycle();

      // random traffic against the scoreboard
      repeat (300) begin
         d_ready = 1'($urandom_range(0, 1));
         pc_src  = ($urandom_range(0, 15) == 0);
         add_res = $urandom;
         rst     = ($urandom_range(0, 63) == 0);
         cycle();
      end
      rst = 1'b0; pc_src = 1'b0; d_ready = 1'b1;
      repeat (8) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued instruction entries (power of 2, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port pc_src  in  1  redirect request from memory stage (branch taken).
REQ-005 SHALL have port add_res  in  32  redirect target address.
REQ-006 SHALL have port imem_addr  out  32  instruction memory byte address (current fetch PC).
REQ-007 SHALL have port imem_rdata  in  32  instruction word at imem_addr, combinational, same cycle.
REQ-008 SHALL have port d_ready  in  1  decode accepts head entry this cycle.
REQ-009 SHALL have port d_valid  out  1  head entry present and valid.
REQ-010 SHALL have port d_inst  out  32  head instruction word.
REQ-011 SHALL have port d_pc  out  32  head entry fetch address + 4.
REQ-012 SHALL have port flush_cnt  out  16  redirect counter (see Configuration).
REQ-013 SHALL have port full_cnt  out  16  queue-full cycle counter (see Configuration).

Function
REQ-014 SHALL hold fetch PC register; imem_addr = fetch PC, combinational.
REQ-015 SHALL push {imem_rdata, fetch PC + 4} at tail and advance fetch PC by 4 on any edge where count < DEPTH and pc_src = 0.
REQ-016 SHALL not push when count = DEPTH, even if pop occurs same cycle; fetch PC holds.
REQ-017 SHALL pop head on edge where d_valid = 1 and d_ready = 1.
REQ-018 SHALL keep count unchanged on simultaneous push and pop; count never exceeds DEPTH nor underflows.
REQ-019 SHALL wrap head/tail pointers modulo DEPTH.
REQ-020 SHALL drive d_valid = (count != 0) and pc_src = 0; d_inst/d_pc = head entry when d_valid, else 0.
REQ-021 SHALL give 1-cycle latency: entry pushed at edge N is visible on d_* during cycle after edge N if it is head.
REQ-022 SHALL deliver entries in fetch order, each exactly once.
REQ-023 SHALL on edge with pc_src = 1 discard all entries (count, pointers to 0), ignore push and pop, load fetch PC with {add_res[31:2], 2'b00}.
REQ-024 SHALL deassert d_valid during any cycle pc_src = 1 so decode never consumes a flushed entry.
REQ-025 SHALL, after redirect, present first target instruction on d_* one cycle after first push from target.

Reset
REQ-026 SHALL on rst = 1 at edge clear fetch PC, count, head, tail, flush_cnt, full_cnt to 0; entry storage not reset.
REQ-027 SHALL give rst priority over pc_src, push and pop in same cycle.
REQ-028 SHALL output d_valid = 0, d_inst = 0, d_pc = 0, imem_addr = 0 in cycle after reset edge.

Configuration
REQ-029 SHALL use macro FETCH_QUEUE_STATS_EN.
REQ-030 SHALL, with macro defined, increment flush_cnt on each edge with pc_src = 1 and increment full_cnt on each edge with count = DEPTH and d_ready = 0, both saturating at 16'hFFFF.
REQ-031 SHALL, without macro, tie flush_cnt and full_cnt to 0 and omit counter logic; all other behaviour identical.

Verification (DEPTH = 4, imem_rdata = 32'hA000_0000 | imem_addr)
REQ-032 SHALL cover: rst one cycle, then d_ready = 1 -> first cycle d_valid = 1 shows d_inst = A000_0000, d_pc = 4; then one entry per cycle, d_pc 8, 0xC, ...
REQ-033 SHALL cover: d_ready = 0 for 6 cycles after reset -> count 4, imem_addr stops at 0x10, d_inst holds A000_0000; d_ready = 1 -> A000_0000..A000_000C in order, then A000_0010.
REQ-034 SHALL cover: 3 entries queued, pc_src = 1, add_res = 0x40 -> d_valid = 0 that cycle; next cycle imem_addr = 0x40; following cycle d_inst = A000_0040, d_pc = 0x44.
REQ-035 SHALL cover: pc_src = 1, add_res = 0x43 -> imem_addr = 0x40 next cycle.
REQ-036 SHALL cover: rst = 1 and pc_src = 1, add_res = 0x80 same edge -> imem_addr = 0, d_valid = 0 next cycle.
REQ-037 SHALL cover: three redirects plus 5 full-stall cycles -> flush_cnt = 3, full_cnt = 5 with FETCH_QUEUE_STATS_EN; both 0 without.
